cp0_core: RTL and testbench
===========================

# cp0_core

Parametrised successor CP0 block for the MIPS32 pipeline. It is instantiated once and sits beside the commit (MEM/WB) boundary. It holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config. It arbitrates precise exceptions, interrupts and ERET for the committing instruction, and produces a same-cycle flush and redirect. Compared with the previous CP0 it adds:
- a configurable external interrupt count with input synchronisers;
- a Count prescaler;
- a sticky Cause.TI;
- a write-masked Status;
- a single fixed priority encoder shared by the flush path and the register-update path;
- ERET returning through an EPC bypass.

## Interface
Parameters:
- NUM_EXT_INT, 5: external interrupt lines (1..5), mapped to Cause.IP[2+:NUM_EXT_INT]. Unused IP bits read 0.
- SYNC_STAGES, 2: flops per int_i synchroniser (≥1).
- TIMER_DIV, 2: Count increments once every TIMER_DIV cycles (≥1).
- EXC_BASE, 32'hBFC0_0380: vector used for all exceptions and interrupts.
- STATUS_WMASK, 32'h0000_FF03: writable Status bits.
- PRID_VAL, 32'h0057_4102: constant PRId.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mtc0_we  in  1  MTC0 write strobe.
- mtc0_addr  in  5  CP0 register number to write.
- mtc0_wdata  in  32  MTC0 write data.
- mfc0_addr  in  5  CP0 register number to read.
- mfc0_rdata  out  32  combinational read data.
- int_i  in  NUM_EXT_INT  asynchronous level interrupts.
- commit_valid  in  1  an instruction is committing this cycle.
- commit_pc  in  32  PC of the committing instruction.
- commit_bd  in  1  committing instruction is in a delay slot.
- commit_exc  in  8  exception flags: [0] AdEL-fetch, [1] RI, [2] Sys, [3] Bp, [4] Ov, [5] Tr, [6] AdEL-data, [7] AdES.
- commit_eret  in  1  committing instruction is ERET.
- commit_badvaddr  in  32  data address for flags [6] and [7].
- flush  out  1  combinational; kill the pipeline and redirect.
- flush_pc  out  32  redirect target, valid when flush=1.
- status_o, cause_o, epc_o  out  32  current register values.

## Operation
Event priority, evaluated only when commit_valid=1, highest first:
- interrupt;
- AdEL-fetch (ExcCode 4);
- RI (10);
- Sys (8);
- Bp (9);
- Ov (12);
- Tr (13);
- AdEL-data (4);
- AdES (5);
- ERET.

Interrupt pending rule:
- Pending when (Cause.IP[7:0] & Status.IM[7:0]) ≠ 0, Status.IE=1 and Status.EXL=0.
- Cause.IP[7] = Cause.TI.
- Cause.IP[6:2] come from the synchroniser outputs.
- Cause.IP[1:0] are software interrupt bits, writable via MTC0.

Exception or interrupt taken:
- flush=1 and flush_pc=EXC_BASE.
- At the next edge, Cause.ExcCode is written (interrupt writes 0).
- If EXL was 0:
  - EPC ← commit_pc − 4 when commit_bd=1, otherwise commit_pc;
  - Cause.BD ← commit_bd;
  - EXL ← 1.
- If EXL was already 1, EPC and BD are unchanged.
- BadVAddr is written on the code-4/5 events only: commit_pc for AdEL-fetch, commit_badvaddr for AdEL-data and AdES.

ERET with no higher-priority event:
- flush=1.
- flush_pc = mtc0_wdata if the same cycle has mtc0_we with addr 14, otherwise EPC.
- EXL ← 0 at the next edge.

MTC0 writes:
- Count (9) write overrides that cycle's increment.
- Compare (11) write clears TI.
- Status (12) is updated as (old & ~STATUS_WMASK) | (wdata & STATUS_WMASK).
- Cause (13): only bits 9:8 are writable.
- EPC (14): full write.
- Writes to all other addresses are ignored.

Simultaneous MTC0 and taken event: the event's writes to EXL, EPC, BD and ExcCode win. MTC0 still updates all other bits.

Timer:
- Prescaler counts 0..TIMER_DIV−1.
- Count increments with 32-bit wrap when the prescaler is at TIMER_DIV−1.
- TI sets on the edge where the incremented Count equals Compare.
- TI stays sticky until the next Compare write. A same-cycle set and clear resolves to clear.

MFC0 read map:
- 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config (32'h8000_0000).
- Any other address reads 0.
- Read bypass: if mtc0_we and mtc0_addr==mfc0_addr, the read returns the value the register will hold after the edge.

## Timing
- flush, flush_pc and mfc0_rdata are combinational from inputs and registers.
- Register updates take effect one edge after the triggering cycle.
- An int_i assertion reaches Cause.IP after SYNC_STAGES+1 edges (synchroniser stages plus the IP register).
- Reset values:
  - Status 32'h0040_0000 (BEV=1);
  - Cause, EPC, BadVAddr, Count, Compare, prescaler, synchronisers and TI all 0;
  - flush=0 while rst=1.
- Reset asserted mid-operation clears state immediately. The first Count increment comes TIMER_DIV edges after reset deasserts.
- commit_valid=0: flush=0, no state change other than timer, synchronisers and MTC0.

## Structure
- Shared package cp0_pkg holds:
  - register-number constants;
  - ExcCode constants;
  - Status/Cause bit-position constants (IE, EXL, IM, IP, TI, BD, ExcCode);
  - the commit_exc bit indices.
- One sub-module, cp0_timer, contains the prescaler, Count, Compare and TI. It exposes count/compare write ports and ti.
- The priority encoder lives in cp0_core and drives both flush and the register-update path.

## Test plan
- **Reset:** rst=1 → Status=32'h0040_0000, all other registers 0, flush=0. Release → Count reads 1 after 2 edges (TIMER_DIV=2).
- **Delay-slot exception:** commit_exc=8'h02, commit_bd=1, pc=32'hBFC0_0104 → flush=1, flush_pc=32'hBFC0_0380; next cycle EPC=32'hBFC0_0100, Cause=32'h8000_0028, EXL=1.
- **Timer interrupt:** Compare=10, Status=32'h0000_8001 → TI set when Count reaches 10. Next commit flushes with ExcCode 0 and EPC=pc. Compare write clears IP7.
- **Nested exception:** with EXL=1, AdES with commit_badvaddr=32'h0000_1233 → EPC unchanged, BadVAddr=32'h0000_1233, ExcCode=5.
- **ERET bypass:** MTC0 EPC=32'h8000_0040 in the same cycle as ERET → flush_pc=32'h8000_0040; EXL=0 next cycle.
- **Masked Status write:** MTC0 Status=32'hFFFF_FFFF → reads 32'h0040_FF03. Same-cycle MFC0 of Status returns 32'h0040_FF03.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, ExcCodes, bit positions, event kinds.
package cp0_pkg;

   // CP0 register numbers
   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;
   localparam logic [4:0] REG_CONFIG   = 5'd16;

   // ExcCode values
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_TR   = 5'd13;

   // Status / Cause bit positions
   localparam int unsigned ST_IE      = 0;
   localparam int unsigned ST_EXL     = 1;
   localparam int unsigned ST_IM_LSB  = 8;
   localparam int unsigned CA_EXC_LSB = 2;
   localparam int unsigned CA_IP_LSB  = 8;
   localparam int unsigned CA_TI      = 30;
   localparam int unsigned CA_BD      = 31;

   // commit_exc bit indices
   localparam int unsigned XB_ADEL_F = 0;
   localparam int unsigned XB_RI     = 1;
   localparam int unsigned XB_SYS    = 2;
   localparam int unsigned XB_BP     = 3;
   localparam int unsigned XB_OV     = 4;
   localparam int unsigned XB_TR     = 5;
   localparam int unsigned XB_ADEL_D = 6;
   localparam int unsigned XB_ADES   = 7;

   localparam logic [31:0] STATUS_RST = 32'h0040_0000;
   localparam logic [31:0] CONFIG_VAL = 32'h8000_0000;

   typedef enum logic [1:0] {EvNone, EvExc, EvEret} cp0_event_e;

   // Assemble the architectural Cause word from its fields.
   function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                              input logic [7:0] ip, input logic [4:0] code);
      logic [31:0] c;
      c = '0;
      c[CA_BD] = bd;
      c[CA_TI] = ti;
      c[CA_IP_LSB +: 8] = ip;
      c[CA_EXC_LSB +: 5] = code;
      return c;
   endfunction

endpackage

// File: rtl/cp0_if.sv
// Commit-boundary bundle between the pipeline and CP0: committing instruction in, flush out.
interface cp0_if;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        commit_bd;
   logic [7:0]  commit_exc;
   logic        commit_eret;
   logic [31:0] commit_badvaddr;
   logic        flush;
   logic [31:0] flush_pc;

   modport master (
      output commit_valid, commit_pc, commit_bd, commit_exc, commit_eret, commit_badvaddr,
      input  flush, flush_pc
   );

   modport slave (
      input  commit_valid, commit_pc, commit_bd, commit_exc, commit_eret, commit_badvaddr,
      output flush, flush_pc
   );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler and sticky timer-interrupt flag.
module cp0_timer #(
   parameter int unsigned TIMER_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti,
   output logic        ti_next
);

   localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [31:0]   count_q, count_d, compare_q, compare_d, count_inc;
   logic          ti_q, ti_d, tick;

   // Next-state for prescaler, Count, Compare and TI
   always_comb begin
      tick      = (presc_q == PW'(TIMER_DIV - 1));
      presc_d   = tick ? '0 : presc_q + PW'(1);
      count_inc = count_q + 32'd1;
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (count_we) begin
         count_d = wdata;
      end else if (tick) begin
         count_d = count_inc;
         if (count_inc == compare_q) ti_d = 1'b1;
      end
      // A Compare write clears TI even if it would set this cycle
      if (compare_we) begin
         compare_d = wdata;
         ti_d      = 1'b0;
      end
   end

   // Timer state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign ti      = ti_q;
   assign ti_next = ti_d;

endmodule

// File: rtl/cp0_core.sv
// CP0 register file with commit-point exception/interrupt/ERET arbitration.
module cp0_core
   import cp0_pkg::*;
#(
   parameter int unsigned NUM_EXT_INT  = 5,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned TIMER_DIV    = 2,
   parameter logic [31:0] EXC_BASE     = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_WMASK = 32'h0000_FF03,
   parameter logic [31:0] PRID_VAL     = 32'h0057_4102
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mtc0_we,
   input  logic [4:0]             mtc0_addr,
   input  logic [31:0]            mtc0_wdata,
   input  logic [4:0]             mfc0_addr,
   output logic [31:0]            mfc0_rdata,
   input  logic [NUM_EXT_INT-1:0] int_i,
   cp0_if.slave                   cif,
   output logic [31:0]            status_o,
   output logic [31:0]            cause_o,
   output logic [31:0]            epc_o
);

   logic [31:0] status_q, status_d, epc_q, epc_d, badv_q, badv_d;
   logic [31:0] count, compare;
   logic [4:0]  exc_code_q, exc_code_d, ip_hw_q, ip_hw_d, ev_code;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic        bd_q, bd_d, ti, ti_next, int_pend, ev_badv_we, rd_byp;
   logic [7:0]  ip;
   logic [31:0] ev_badv;
   cp0_event_e  ev;
   logic [NUM_EXT_INT-1:0] sync_q [SYNC_STAGES];

   wire wr_count   = mtc0_we && (mtc0_addr == REG_COUNT);
   wire wr_compare = mtc0_we && (mtc0_addr == REG_COMPARE);
   wire wr_status  = mtc0_we && (mtc0_addr == REG_STATUS);
   wire wr_cause   = mtc0_we && (mtc0_addr == REG_CAUSE);
   wire wr_epc     = mtc0_we && (mtc0_addr == REG_EPC);

   cp0_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (wr_count),
      .compare_we (wr_compare),
      .wdata      (mtc0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti),
      .ti_next    (ti_next)
   );

   // External interrupt synchroniser chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= int_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign ip       = {ti, ip_hw_q, ip_sw_q};
   assign int_pend = |(ip & status_q[ST_IM_LSB +: 8]) && status_q[ST_IE] && !status_q[ST_EXL];

   // Fixed-priority event encoder shared by flush and register update
   always_comb begin
      ev         = EvNone;
      ev_code    = EXC_INT;
      ev_badv_we = 1'b0;
      ev_badv    = cif.commit_badvaddr;
      if (cif.commit_valid) begin
         ev = EvExc;
         if (int_pend)                      ev_code = EXC_INT;
         else if (cif.commit_exc[XB_ADEL_F]) begin
            ev_code = EXC_ADEL; ev_badv_we = 1'b1; ev_badv = cif.commit_pc;
         end
         else if (cif.commit_exc[XB_RI])    ev_code = EXC_RI;
         else if (cif.commit_exc[XB_SYS])   ev_code = EXC_SYS;
         else if (cif.commit_exc[XB_BP])    ev_code = EXC_BP;
         else if (cif.commit_exc[XB_OV])    ev_code = EXC_OV;
         else if (cif.commit_exc[XB_TR])    ev_code = EXC_TR;
         else if (cif.commit_exc[XB_ADEL_D]) begin
            ev_code = EXC_ADEL; ev_badv_we = 1'b1;
         end
         else if (cif.commit_exc[XB_ADES]) begin
            ev_code = EXC_ADES; ev_badv_we = 1'b1;
         end
         else if (cif.commit_eret)          ev = EvEret;
         else                               ev = EvNone;
      end
   end

   // Flush and redirect; ERET target bypasses a same-cycle EPC write
   always_comb begin
      cif.flush    = !rst && (ev != EvNone);
      cif.flush_pc = EXC_BASE;
      if (ev == EvEret) cif.flush_pc = wr_epc ? mtc0_wdata : epc_q;
   end

   // Next-state: MTC0 first, then the committed event overrides its fields
   always_comb begin
      status_d   = wr_status ? ((status_q & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK))
                             : status_q;
      ip_sw_d    = wr_cause ? mtc0_wdata[CA_IP_LSB +: 2] : ip_sw_q;
      epc_d      = wr_epc ? mtc0_wdata : epc_q;
      bd_d       = bd_q;
      exc_code_d = exc_code_q;
      badv_d     = badv_q;
      ip_hw_d    = '0;
      ip_hw_d[NUM_EXT_INT-1:0] = sync_q[SYNC_STAGES-1];
      if (ev == EvExc) begin
         exc_code_d = ev_code;
         if (!status_q[ST_EXL]) begin
            epc_d = cif.commit_bd ? cif.commit_pc - 32'd4 : cif.commit_pc;
            bd_d  = cif.commit_bd;
         end
         status_d[ST_EXL] = 1'b1;
         if (ev_badv_we) badv_d = ev_badv;
      end else if (ev == EvEret) begin
         status_d[ST_EXL] = 1'b0;
      end
   end

   // Architectural register state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q   <= STATUS_RST;
         epc_q      <= '0;
         badv_q     <= '0;
         exc_code_q <= '0;
         ip_hw_q    <= '0;
         ip_sw_q    <= '0;
         bd_q       <= 1'b0;
      end else begin
         status_q   <= status_d;
         epc_q      <= epc_d;
         badv_q     <= badv_d;
         exc_code_q <= exc_code_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
         bd_q       <= bd_d;
      end
   end

   // MFC0 read mux with same-cycle write bypass
   always_comb begin
      rd_byp = mtc0_we && (mtc0_addr == mfc0_addr);
      case (mfc0_addr)
         REG_BADVADDR: mfc0_rdata = badv_q;
         REG_COUNT:    mfc0_rdata = rd_byp ? mtc0_wdata : count;
         REG_COMPARE:  mfc0_rdata = rd_byp ? mtc0_wdata : compare;
         REG_STATUS:   mfc0_rdata = rd_byp ? status_d : status_q;
         REG_CAUSE:    mfc0_rdata = rd_byp ? pack_cause(bd_d, ti_next, {ti_next, ip_hw_d, ip_sw_d},
                                                        exc_code_d)
                                           : cause_o;
         REG_EPC:      mfc0_rdata = rd_byp ? epc_d : epc_q;
         REG_PRID:     mfc0_rdata = PRID_VAL;
         REG_CONFIG:   mfc0_rdata = CONFIG_VAL;
         default:      mfc0_rdata = '0;
      endcase
   end

   assign status_o = status_q;
   assign cause_o  = pack_cause(bd_q, ti, ip, exc_code_q);
   assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_core.sv
// Directed self-checking bench for cp0_core with default parameters.
module tb_cp0_core;

   logic        clk, rst;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr, mfc0_addr;
   logic [31:0] mtc0_wdata, mfc0_rdata;
   logic [4:0]  int_i;
   logic [31:0] status_o, cause_o, epc_o;
   int          n_vec, n_err;

   cp0_if cif ();

   cp0_core dut (
      .clk        (clk),
      .rst        (rst),
      .mtc0_we    (mtc0_we),
      .mtc0_addr  (mtc0_addr),
      .mtc0_wdata (mtc0_wdata),
      .mfc0_addr  (mfc0_addr),
      .mfc0_rdata (mfc0_rdata),
      .int_i      (int_i),
      .cif        (cif.slave),
      .status_o   (status_o),
      .cause_o    (cause_o),
      .epc_o      (epc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cif.commit_valid    = 1'b0;
      cif.commit_pc       = '0;
      cif.commit_bd       = 1'b0;
      cif.commit_exc      = '0;
      cif.commit_eret     = 1'b0;
      cif.commit_badvaddr = '0;
      mtc0_we             = 1'b0;
      mtc0_addr           = '0;
      mtc0_wdata          = '0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      mfc0_addr = a;
      #1;
      d = mfc0_rdata;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      mtc0_we    = 1'b1;
      mtc0_addr  = a;
      mtc0_wdata = d;
   endtask

   logic [31:0] r;
   logic        found;

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      int_i = '0;
      mfc0_addr = '0;
      idle();
      step();
      step();

      // Reset state
      check("rst_status", status_o, 32'h0040_0000);
      check("rst_cause", cause_o, 32'h0);
      check("rst_epc", epc_o, 32'h0);
      rd(5'd8, r);  check("rst_badv", r, 32'h0);
      rd(5'd9, r);  check("rst_count", r, 32'h0);
      cif.commit_valid = 1'b1;
      cif.commit_exc   = 8'h01;
      #1;
      check("rst_noflush", cif.flush, 1'b0);
      idle();

      // Release: first Count increment after TIMER_DIV edges
      rst = 1'b0;
      step();
      rd(5'd9, r);  check("count_e1", r, 32'd0);
      step();
      rd(5'd9, r);  check("count_e2", r, 32'd1);

      // RI in delay slot
      cif.commit_valid = 1'b1;
      cif.commit_exc   = 8'h02;
      cif.commit_bd    = 1'b1;
      cif.commit_pc    = 32'hBFC0_0104;
      #1;
      check("ds_flush", cif.flush, 1'b1);
      check("ds_flush_pc", cif.flush_pc, 32'hBFC0_0380);
      step();
      idle();
      check("ds_epc", epc_o, 32'hBFC0_0100);
      check("ds_cause", cause_o, 32'h8000_0028);
      check("ds_status", status_o, 32'h0040_0002);

      // Nested AdES with EXL=1
      cif.commit_valid    = 1'b1;
      cif.commit_exc      = 8'h80;
      cif.commit_pc       = 32'h0040_0020;
      cif.commit_badvaddr = 32'h0000_1233;
      #1;
      check("nest_flush", cif.flush, 1'b1);
      step();
      idle();
      check("nest_epc", epc_o, 32'hBFC0_0100);
      rd(5'd8, r);  check("nest_badv", r, 32'h0000_1233);
      check("nest_cause", cause_o, 32'h8000_0014);

      // ERET with same-cycle EPC write
      cif.commit_valid = 1'b1;
      cif.commit_eret  = 1'b1;
      wr(5'd14, 32'h8000_0040);
      #1;
      check("eret_flush", cif.flush, 1'b1);
      check("eret_byp_pc", cif.flush_pc, 32'h8000_0040);
      step();
      idle();
      check("eret_status", status_o, 32'h0040_0000);
      check("eret_epc", epc_o, 32'h8000_0040);

      // Masked Status write with read bypass
      wr(5'd12, 32'hFFFF_FFFF);
      rd(5'd12, r);  check("st_byp", r, 32'h0040_FF03);
      step();
      idle();
      check("st_mask", status_o, 32'h0040_FF03);
      wr(5'd12, 32'h0000_8001);
      step();
      idle();
      check("st_8001", status_o, 32'h0040_8001);

      // Timer interrupt
      wr(5'd11, 32'd10);
      step();
      wr(5'd9, 32'd0);
      step();
      idle();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (cause_o[30]) found = 1'b1;
      end
      check("ti_set", found, 1'b1);
      rd(5'd9, r);  check("ti_count", r, 32'd10);
      check("ti_nocommit", cif.flush, 1'b0);
      cif.commit_valid = 1'b1;
      cif.commit_pc    = 32'h0040_0100;
      #1;
      check("int_flush", cif.flush, 1'b1);
      check("int_flush_pc", cif.flush_pc, 32'hBFC0_0380);
      step();
      idle();
      check("int_cause", cause_o, 32'h4000_8000);
      check("int_epc", epc_o, 32'h0040_0100);
      check("int_status", status_o, 32'h0040_8003);
      wr(5'd11, 32'd1000);
      step();
      idle();
      check("ti_clear", cause_o, 32'h0);

      // External interrupt latency: SYNC_STAGES + 1 edges
      int_i = 5'b00001;
      step();
      step();
      check("ext_early", cause_o, 32'h0);
      step();
      check("ext_ip2", cause_o, 32'h0000_0400);
      int_i = '0;
      repeat (4) step();

      // Cause software bits only
      wr(5'd13, 32'hFFFF_FFFF);
      rd(5'd13, r);  check("cause_byp", r, 32'h0000_0300);
      step();
      idle();
      check("cause_sw", cause_o, 32'h0000_0300);

      // Count bypass and constant registers
      wr(5'd9, 32'h1234_5678);
      rd(5'd9, r);  check("count_byp", r, 32'h1234_5678);
      step();
      idle();
      rd(5'd15, r); check("prid", r, 32'h0057_4102);
      rd(5'd16, r); check("config", r, 32'h8000_0000);
      rd(5'd3, r);  check("unmapped", r, 32'h0);
      rd(5'd11, r); check("compare", r, 32'd1000);

      // ERET returning through stored EPC
      cif.commit_valid = 1'b1;
      cif.commit_eret  = 1'b1;
      #1;
      check("eret_epc_pc", cif.flush_pc, 32'h0040_0100);
      step();
      idle();
      check("eret2_status", status_o, 32'h0040_8001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
